// File: rtl/bp_be_stride_prefetcher.sv
// Stride prefetch engine: a direct-mapped, tagged reference prediction table trained by
// load/store addresses, plus a burst FSM that issues prefetch addresses over valid/ready.
module bp_be_stride_prefetcher #(
   parameter int vaddr_width_p  = 39,
   parameter int rpt_entries_p  = 16,
   parameter int tag_width_p    = 10,
   parameter int stride_width_p = 12,
   parameter int conf_width_p   = 2,
   parameter int conf_thresh_p  = 2,
   parameter int degree_max_p   = 4,
   localparam int DegW          = $clog2(degree_max_p+1)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     enable_i,
   input  logic                     flush_i,
   input  logic [DegW-1:0]          degree_i,
   input  logic                     train_v_i,
   input  logic [vaddr_width_p-1:0] train_pc_i,
   input  logic [vaddr_width_p-1:0] train_addr_i,
   output logic                     pf_v_o,
   output logic [vaddr_width_p-1:0] pf_addr_o,
   input  logic                     pf_ready_i,
   output logic                     busy_o
);
   localparam int VA = vaddr_width_p;
   localparam int SW = stride_width_p;
   localparam int CW = conf_width_p;
   localparam int TW = tag_width_p;
   localparam int IW = $clog2(rpt_entries_p);
   localparam logic [CW-1:0]   ConfMax = {CW{1'b1}};
   localparam logic [CW:0]     Thresh  = (CW+1)'(conf_thresh_p);
   localparam logic [DegW-1:0] DegMax  = DegW'(degree_max_p);

   typedef enum logic {IDLE, ISSUE} state_e;

   logic          valid_q  [rpt_entries_p];
   logic [TW-1:0] tag_q    [rpt_entries_p];
   logic [VA-1:0] last_q   [rpt_entries_p];
   logic [SW-1:0] stride_q [rpt_entries_p];
   logic [CW-1:0] conf_q   [rpt_entries_p];

   state_e          state_q, state_d;
   logic [VA-1:0]   pf_addr_q, pf_addr_d;
   logic [VA-1:0]   pf_stride_q, pf_stride_d;
   logic [DegW-1:0] cnt_q, cnt_d;

   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic          hit, fits, trigger;
   logic [VA-1:0] delta, stride_ext;
   logic [SW-1:0] stride_d;
   logic [CW-1:0] conf_d;
   logic [DegW-1:0] deg_clamped;

   assign idx = train_pc_i[1 +: IW];
   assign tag = train_pc_i[1+IW +: TW];

   // Table lookup and the trained values that will be written back at this edge.
   always_comb begin
      hit      = valid_q[idx] && (tag_q[idx] == tag);
      delta    = train_addr_i - last_q[idx];
      fits     = ({{(VA-SW){delta[SW-1]}}, delta[SW-1:0]} == delta);
      stride_d = stride_q[idx];
      conf_d   = conf_q[idx];
      if (!hit) begin
         stride_d = '0;
         conf_d   = '0;
      end else if (fits && (delta[SW-1:0] == stride_q[idx]) && (stride_q[idx] != '0)) begin
         if (conf_q[idx] != ConfMax) conf_d = conf_q[idx] + 1'b1;
      end else if (conf_q[idx] == '0) begin
         stride_d = fits ? delta[SW-1:0] : '0;
      end else begin
         conf_d = conf_q[idx] - 1'b1;
      end
      stride_ext  = {{(VA-SW){stride_d[SW-1]}}, stride_d};
      deg_clamped = (degree_i > DegMax) ? DegMax : degree_i;
      trigger     = train_v_i && hit && ({1'b0, conf_d} >= Thresh) && (state_q == IDLE)
                    && enable_i && (degree_i != '0) && !flush_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < rpt_entries_p; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            last_q[i]   <= '0;
            stride_q[i] <= '0;
            conf_q[i]   <= '0;
         end
      end else if (flush_i) begin
         for (int i = 0; i < rpt_entries_p; i++) valid_q[i] <= 1'b0;
      end else if (train_v_i) begin
         valid_q[idx]  <= 1'b1;
         tag_q[idx]    <= tag;
         last_q[idx]   <= train_addr_i;
         stride_q[idx] <= stride_d;
         conf_q[idx]   <= conf_d;
      end
   end

   // Burst FSM; disable or flush drops an in-flight burst since prefetches are only hints.
   always_comb begin
      state_d     = state_q;
      pf_addr_d   = pf_addr_q;
      pf_stride_d = pf_stride_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (trigger) begin
               state_d     = ISSUE;
               pf_addr_d   = train_addr_i + stride_ext;
               pf_stride_d = stride_ext;
               cnt_d       = deg_clamped;
            end
         end
         ISSUE: begin
            if (flush_i || !enable_i) begin
               state_d = IDLE;
            end else if (pf_ready_i) begin
               pf_addr_d = pf_addr_q + pf_stride_q;
               cnt_d     = cnt_q - 1'b1;
               if (cnt_q == DegW'(1)) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         pf_addr_q   <= '0;
         pf_stride_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         pf_addr_q   <= pf_addr_d;
         pf_stride_q <= pf_stride_d;
         cnt_q       <= cnt_d;
      end
   end

   assign pf_v_o    = (state_q == ISSUE);
   assign busy_o    = pf_v_o;
   assign pf_addr_o = pf_addr_q;

endmodule
